gcd_controller: RTL and testbench

//  FSM that sequences the 16-bit subtract-based GCD datapath. Accepts two operands over a

---
 rtl/gcd_pkg.sv | 29 ++
 rtl/gcd_iter_cnt.sv | 44 ++++
 rtl/gcd_controller.sv | 165 ++++++++++++++++
 tb/tb_gcd_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// ---------------------------------------------------------------------------
// gcd_pkg
// Shared constants for the subtract-based GCD controller:
//   - controller state encodings (exposed on the debug state port)
//   - datapath mux select encodings
//   - default iteration counter width and timeout limit
// ---------------------------------------------------------------------------
package gcd_pkg;

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_B = 3'd1;
    localparam logic [2:0] ST_CALC   = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    // Subtractor operand selects (sel1 = x operand, sel2 = y operand)
    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;

    // Register input bus select
    localparam logic SEL_DIN = 1'b1;
    localparam logic SEL_SUB = 1'b0;

    // Iteration counter defaults
    localparam int          DEF_ITER_W   = 16;
    localparam logic [15:0] DEF_MAX_ITER = 16'hFFFF;

endpackage

// File: rtl/gcd_iter_cnt.sv
// ---------------------------------------------------------------------------
// gcd_iter_cnt
// Counts subtract iterations. Clear has priority over increment; the count
// saturates at MAX_ITER and o_tc flags that terminal value.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_clr         synchronous clear to zero
//   i_inc         increment (ignored once saturated)
//   o_cnt         current count
//   o_tc          count equals MAX_ITER
// ---------------------------------------------------------------------------
module gcd_iter_cnt
    import gcd_pkg::*;
#(
    parameter int                ITER_W   = DEF_ITER_W,
    parameter logic [ITER_W-1:0] MAX_ITER = DEF_MAX_ITER
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_inc,
    output logic [ITER_W-1:0] o_cnt,
    output logic              o_tc
);

    logic [ITER_W-1:0] r_cnt;
    logic              w_tc;

    assign w_tc = (r_cnt == MAX_ITER);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

// File: rtl/gcd_controller.sv
// ---------------------------------------------------------------------------
// gcd_controller
// Sequences a 16-bit subtract-based GCD datapath. Operand A then operand B
// are taken from the datapath data_in bus over a valid/ready handshake, then
// one conditional subtract is issued per cycle until A == B.
//
// Handshake: an operand transfers on a rising edge where i_opnd_valid and
// o_opnd_ready are both high; o_opnd_ready never depends on i_opnd_valid.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_opnd_valid          operand on data_in is valid (A first, then B)
//   o_opnd_ready          controller accepts an operand this cycle
//   i_abort               synchronous cancel (ignored in IDLE)
//   i_gt, i_lt, i_eq      datapath compare flags for A vs B
//   o_ld_a, o_ld_b        datapath register load enables
//   o_sel1, o_sel2        subtractor x / y operand selects (0=A, 1=B)
//   o_sel_in              register bus select (1=data_in, 0=subtractor)
//   o_busy                operation in progress (WAIT_B, CALC)
//   o_done                one-cycle pulse, GCD held in datapath A
//   o_err                 one-cycle pulse, timeout / abort / illegal flags
//   o_iter_cnt            subtracts performed in current/last operation
//   o_state               debug view of the controller state
// ---------------------------------------------------------------------------
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int                ITER_W   = DEF_ITER_W,
    parameter logic [ITER_W-1:0] MAX_ITER = DEF_MAX_ITER
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_opnd_valid,
    output logic              o_opnd_ready,
    input  logic              i_abort,
    input  logic              i_gt,
    input  logic              i_lt,
    input  logic              i_eq,
    output logic              o_ld_a,
    output logic              o_ld_b,
    output logic              o_sel1,
    output logic              o_sel2,
    output logic              o_sel_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ITER_W-1:0] o_iter_cnt,
    output logic [2:0]        o_state
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_ready, w_ld_a, w_ld_b, w_sel1, w_sel2, w_sel_in;
    logic       w_busy, w_done, w_err;
    logic       w_clr, w_inc, w_tc;

    gcd_iter_cnt #(
        .ITER_W   (ITER_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_clr),
        .i_inc (w_inc),
        .o_cnt (o_iter_cnt),
        .o_tc  (w_tc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Mealy output decode. Abort wins over everything
    // outside IDLE; equality wins over the timeout so a run that converges
    // exactly on the last allowed subtract still reports done.
    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_ld_a   = 1'b0;
        w_ld_b   = 1'b0;
        w_sel1   = SEL_A;
        w_sel2   = SEL_A;
        w_sel_in = SEL_SUB;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_clr    = 1'b0;
        w_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (i_opnd_valid) begin
                    w_sel_in = SEL_DIN;
                    w_ld_a   = 1'b1;
                    w_clr    = 1'b1;
                    w_next   = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_next = ST_ERR;
                end else begin
                    w_ready = 1'b1;
                    if (i_opnd_valid) begin
                        w_sel_in = SEL_DIN;
                        w_ld_b   = 1'b1;
                        w_next   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (i_abort) begin
                    w_next = ST_ERR;
                end else if (i_eq) begin
                    w_next = ST_DONE;
                end else if (w_tc) begin
                    w_next = ST_ERR;
                end else if (i_gt) begin
                    w_sel1 = SEL_A;
                    w_sel2 = SEL_B;
                    w_ld_a = 1'b1;
                    w_inc  = 1'b1;
                end else if (i_lt) begin
                    w_sel1 = SEL_B;
                    w_sel2 = SEL_A;
                    w_ld_b = 1'b1;
                    w_inc  = 1'b1;
                end else begin
                    w_next = ST_ERR;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_err  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Reset gates the outputs directly so a Mealy load driven by a still
    // high opnd_valid cannot leak through while reset is asserted.
    assign o_opnd_ready = w_ready  & ~i_rst;
    assign o_ld_a       = w_ld_a   & ~i_rst;
    assign o_ld_b       = w_ld_b   & ~i_rst;
    assign o_sel1       = w_sel1   & ~i_rst;
    assign o_sel2       = w_sel2   & ~i_rst;
    assign o_sel_in     = w_sel_in & ~i_rst;
    assign o_busy       = w_busy   & ~i_rst;
    assign o_done       = w_done   & ~i_rst;
    assign o_err        = w_err    & ~i_rst;
    assign o_state      = r_state;

endmodule

// File: tb/tb_gcd_controller.sv
module tb_gcd_controller;
  import gcd_pkg::*;

  localparam int          ITER_W = 16;
  localparam logic [15:0] MAXI   = 16'd8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        opnd_valid = 1'b0;
  logic        abort      = 1'b0;
  logic        force_none = 1'b0;
  logic [15:0] data_in    = 16'h0000;
  logic        opnd_ready, ld_a, ld_b, sel1, sel2, sel_in, busy, done, err;
  logic [15:0] iter_cnt;
  logic [2:0]  state;
  logic        gt, lt, eq;

  // ---------------- reference datapath ----------------
  logic [15:0] dp_a = 16'h0000;
  logic [15:0] dp_b = 16'h0000;
  logic [15:0] dp_x, dp_y, dp_bus;

  assign dp_x   = sel1 ? dp_b : dp_a;
  assign dp_y   = sel2 ? dp_b : dp_a;
  assign dp_bus = sel_in ? data_in : (dp_x - dp_y);
  assign gt     = !force_none && (dp_a > dp_b);
  assign lt     = !force_none && (dp_a < dp_b);
  assign eq     = !force_none && (dp_a == dp_b);

  always @(posedge clk) begin
    if (ld_a) dp_a <= dp_bus;
    if (ld_b) dp_b <= dp_bus;
  end

  gcd_controller #(
    .ITER_W   (ITER_W),
    .MAX_ITER (MAXI)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_opnd_valid (opnd_valid),
    .o_opnd_ready (opnd_ready),
    .i_abort      (abort),
    .i_gt         (gt),
    .i_lt         (lt),
    .i_eq         (eq),
    .o_ld_a       (ld_a),
    .o_ld_b       (ld_b),
    .o_sel1       (sel1),
    .o_sel2       (sel2),
    .o_sel_in     (sel_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_iter_cnt   (iter_cnt),
    .o_state      (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          gap;
    logic        exp_done;
    logic [15:0] exp_res;
    logic [15:0] exp_iter;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic send_operand(input logic [15:0] val, input bit is_b);
    @(negedge clk);
    data_in    = val;
    opnd_valid = 1'b1;
    #1;
    check(is_b ? "ready_b" : "ready_a", {31'd0, opnd_ready}, 32'd1);
    check(is_b ? "ld_b_on_accept" : "ld_a_on_accept", {31'd0, is_b ? ld_b : ld_a}, 32'd1);
    @(posedge clk);
    #1;
    opnd_valid = 1'b0;
    data_in    = 16'hDEAD;
  endtask

  task automatic wait_result(output int cyc, output logic d, output logic e);
    cyc = 0;
    d   = 1'b0;
    e   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("first_calc_state", {29'd0, state}, {29'd0, ST_CALC});
        check("busy_in_calc", {31'd0, busy}, 32'd1);
      end
      if (done || err) begin
        cyc = i;
        d   = done;
        e   = err;
        break;
      end
    end
    check("result_seen", {31'd0, d | e}, 32'd1);
  endtask

  task automatic run_vector(input vec_t v);
    int   cyc;
    logic d, e;
    send_operand(v.a, 1'b0);
    for (int g = 0; g < v.gap; g++) begin
      @(negedge clk);
      check("gap_a_held", {16'd0, dp_a}, {16'd0, v.a});
      check("gap_wait_b", {29'd0, state}, {29'd0, ST_WAIT_B});
    end
    send_operand(v.b, 1'b1);
    wait_result(cyc, d, e);
    check("done_flag", {31'd0, d}, {31'd0, v.exp_done});
    check("err_flag", {31'd0, e}, {31'd0, !v.exp_done});
    check("latency", cyc, v.exp_cycles);
    check("iter_cnt", {16'd0, iter_cnt}, {16'd0, v.exp_iter});
    if (v.exp_done) check("gcd_result", {16'd0, dp_a}, {16'd0, v.exp_res});
    @(negedge clk);
    check("pulse_done_low", {31'd0, done}, 32'd0);
    check("pulse_err_low", {31'd0, err}, 32'd0);
    check("idle_ready", {31'd0, opnd_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("iter_hold", {16'd0, iter_cnt}, {16'd0, v.exp_iter});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //          a      b     gap done res    iter  cycles
    vecs[0] = '{16'd12, 16'd18, 0, 1'b1, 16'd6, 16'd2, 4};
    vecs[1] = '{16'd7,  16'd7,  0, 1'b1, 16'd7, 16'd0, 2};
    vecs[2] = '{16'd0,  16'd5,  0, 1'b0, 16'd0, 16'd8, 10};
    vecs[3] = '{16'd48, 16'd18, 3, 1'b1, 16'd6, 16'd4, 6};
    vecs[4] = '{16'd9,  16'd1,  0, 1'b1, 16'd1, 16'd8, 10};
    vecs[5] = '{16'd10, 16'd1,  0, 1'b0, 16'd0, 16'd8, 10};
    vecs[6] = '{16'd21, 16'd6,  1, 1'b1, 16'd3, 16'd4, 6};
    vecs[7] = '{16'd5,  16'd0,  0, 1'b0, 16'd0, 16'd8, 10};

    // Reset state, with opnd_valid high to show loads stay gated
    opnd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, opnd_ready}, 32'd0);
    check("rst_ld_a", {31'd0, ld_a}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_iter", {16'd0, iter_cnt}, 32'd0);
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});
    opnd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, opnd_ready}, 32'd1);

    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // abort in IDLE is ignored
    @(negedge clk);
    abort = 1'b1;
    #1 check("idle_abort_ready", {31'd0, opnd_ready}, 32'd1);
    @(negedge clk);
    check("idle_abort_state", {29'd0, state}, {29'd0, ST_IDLE});
    check("idle_abort_no_err", {31'd0, err}, 32'd0);
    abort = 1'b0;

    // abort in the 3rd CALC cycle of 100/3
    send_operand(16'd100, 1'b0);
    send_operand(16'd3, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_no_ld_a", {31'd0, ld_a}, 32'd0);
    check("abort_no_ld_b", {31'd0, ld_b}, 32'd0);
    check("abort_a_before", {16'd0, dp_a}, 32'd94);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_err", {31'd0, err}, 32'd1);
    check("abort_a_kept", {16'd0, dp_a}, 32'd94);
    check("abort_iter", {16'd0, iter_cnt}, 32'd2);
    @(negedge clk);
    check("abort_idle", {29'd0, state}, {29'd0, ST_IDLE});
    check("abort_ready", {31'd0, opnd_ready}, 32'd1);

    // abort in WAIT_B outranks a simultaneous operand
    send_operand(16'd4, 1'b0);
    @(negedge clk);
    abort      = 1'b1;
    opnd_valid = 1'b1;
    data_in    = 16'd2;
    #1;
    check("wb_abort_no_ld_b", {31'd0, ld_b}, 32'd0);
    check("wb_abort_not_ready", {31'd0, opnd_ready}, 32'd0);
    @(posedge clk);
    #1;
    abort      = 1'b0;
    opnd_valid = 1'b0;
    @(negedge clk);
    check("wb_abort_err", {31'd0, err}, 32'd1);

    // illegal compare flags in CALC
    send_operand(16'd12, 1'b0);
    send_operand(16'd18, 1'b1);
    @(negedge clk);
    force_none = 1'b1;
    #1;
    check("bad_flags_no_ld", {30'd0, ld_a, ld_b}, 32'd0);
    @(posedge clk);
    #1 force_none = 1'b0;
    @(negedge clk);
    check("bad_flags_err", {31'd0, err}, 32'd1);
    check("bad_flags_state", {29'd0, state}, {29'd0, ST_ERR});

    // asynchronous reset mid-CALC, then a fresh run
    send_operand(16'd12, 1'b0);
    send_operand(16'd18, 1'b1);
    @(negedge clk);
    check("pre_rst_ld_b", {31'd0, ld_b}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_loads", {30'd0, ld_a, ld_b}, 32'd0);
    check("arst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("arst_iter", {16'd0, iter_cnt}, 32'd0);
    check("arst_state", {29'd0, state}, {29'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;
    run_vector(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
